// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
package wb_arbiter_pkg;

   localparam int REG_IDX_W     = 5;
   localparam int XLEN          = 32;
   localparam int N_REQ_DEFAULT = 3;

   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_LSU = 1;
   localparam int unsigned REQ_DBG = 2;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]      xword_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin one-hot grant: search starts at ptr and wraps modulo N.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   localparam int SW = PW + 1;

   logic [SW-1:0] pos;
   logic          found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      pos   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + SW'(k);
         if (pos >= SW'(N)) pos = pos - SW'(N);
         if (!found && req[pos[PW-1:0]]) begin
            grant[pos[PW-1:0]] = 1'b1;
            found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter with a one-stage registered output.
// Define WB_ARBITER_SCOREBOARD_EN to add the pending-write busy_mask scoreboard.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       hold,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [REG_IDX_W*N_REQ-1:0] req_sel,
   input  logic [XLEN*N_REQ-1:0]      req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       w_en,
   output logic [REG_IDX_W-1:0]       w_sel,
   output logic [XLEN-1:0]            w_data
`ifdef WB_ARBITER_SCOREBOARD_EN
   ,
   input  logic                       rsv_en,
   input  logic [REG_IDX_W-1:0]       rsv_sel,
   output logic [(1<<REG_IDX_W)-1:0]  busy_mask
`endif
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    rr_ptr_nxt;
   logic [PW-1:0]    g_idx;
   logic [N_REQ-1:0] req_eff;
   logic [N_REQ-1:0] grant;
   logic             xfer;
   reg_idx_t         g_sel;
   xword_t           g_data;

   assign req_eff   = hold ? '0 : req_valid;
   assign req_ready = grant;
   assign xfer      = |grant;

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
      .req   (req_eff),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   always_comb begin
      g_idx  = '0;
      g_sel  = '0;
      g_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            g_idx  = PW'(i);
            g_sel  = req_sel[i*REG_IDX_W +: REG_IDX_W];
            g_data = req_data[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (xfer) rr_ptr_nxt = (g_idx == PW'(N_REQ-1)) ? '0 : g_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         w_en   <= 1'b0;
         w_sel  <= '0;
         w_data <= '0;
      end else begin
         rr_ptr <= rr_ptr_nxt;
         w_en   <= xfer && (g_sel != '0);
         if (xfer) begin
            w_sel  <= g_sel;
            w_data <= g_data;
         end
      end
   end

`ifdef WB_ARBITER_SCOREBOARD_EN
   logic [(1<<REG_IDX_W)-1:0] busy_nxt;

   // Set is applied after clear so a same-edge reservation wins.
   always_comb begin
      busy_nxt = busy_mask;
      if (w_en)   busy_nxt[w_sel]   = 1'b0;
      if (rsv_en) busy_nxt[rsv_sel] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_mask <= '0;
      else        busy_mask <= busy_nxt;
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (N_REQ = 3).
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hold;
   logic [2:0]  req_valid;
   logic [14:0] req_sel;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        w_en;
   logic [4:0]  w_sel;
   logic [31:0] w_data;
`ifdef WB_ARBITER_SCOREBOARD_EN
   logic        rsv_en;
   logic [4:0]  rsv_sel;
   logic [31:0] busy_mask;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.N_REQ(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (hold),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_data  (req_data),
      .req_ready (req_ready),
      .w_en      (w_en),
      .w_sel     (w_sel),
      .w_data    (w_data)
`ifdef WB_ARBITER_SCOREBOARD_EN
      ,
      .rsv_en    (rsv_en),
      .rsv_sel   (rsv_sel),
      .busy_mask (busy_mask)
`endif
   );

   typedef struct {
      logic        hold;
      logic [2:0]  valid;
      logic [14:0] sel;
      logic [95:0] data;
      logic [2:0]  ready;
      logic        w_en;
      logic [4:0]  w_sel;
      logic [31:0] w_data;
   } vec_t;

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0001;
   localparam logic [31:0] D2 = 32'h3333_0002;
   localparam logic [14:0] SA = {5'd3, 5'd2, 5'd1};
   localparam logic [95:0] DA = {D2, D1, D0};

   vec_t vecs[14];

   function automatic vec_t mkv(logic h, logic [2:0] v, logic [14:0] s, logic [95:0] d,
                                logic [2:0] r, logic e, logic [4:0] ws, logic [31:0] wd);
      vec_t t;
      t.hold = h; t.valid = v; t.sel = s; t.data = d;
      t.ready = r; t.w_en = e; t.w_sel = ws; t.w_data = wd;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic h, input logic [2:0] v, input logic [14:0] s,
                        input logic [95:0] d);
      hold = h; req_valid = v; req_sel = s; req_data = d;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 3'b000, '0, '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 3'b000, '0, '0);
`ifdef WB_ARBITER_SCOREBOARD_EN
      rsv_en = 1'b0; rsv_sel = '0;
`endif
      // Table: ptr sequence 0,1,2,0,1,1,2,2,2,0,1,0,0,1 before each row.
      vecs[0]  = mkv(0, 3'b001, {5'd0, 5'd0, 5'd5}, {64'h0, 32'hDEADBEEF}, 3'b001, 1, 5, 32'hDEADBEEF);
      vecs[1]  = mkv(0, 3'b111, SA, DA, 3'b010, 1, 2, D1);
      vecs[2]  = mkv(0, 3'b111, SA, DA, 3'b100, 1, 3, D2);
      vecs[3]  = mkv(0, 3'b111, SA, DA, 3'b001, 1, 1, D0);
      vecs[4]  = mkv(0, 3'b000, SA, DA, 3'b000, 0, 1, D0);
      vecs[5]  = mkv(0, 3'b010, '0, {32'h0, 32'h1234, 32'h0}, 3'b010, 0, 0, 32'h1234);
      vecs[6]  = mkv(1, 3'b111, SA, DA, 3'b000, 0, 0, 32'h1234);
      vecs[7]  = mkv(1, 3'b111, SA, DA, 3'b000, 0, 0, 32'h1234);
      vecs[8]  = mkv(0, 3'b111, SA, DA, 3'b100, 1, 3, D2);
      vecs[9]  = mkv(0, 3'b101, SA, DA, 3'b001, 1, 1, D0);
      vecs[10] = mkv(0, 3'b101, SA, DA, 3'b100, 1, 3, D2);
      vecs[11] = mkv(0, 3'b100, SA, DA, 3'b100, 1, 3, D2);
      vecs[12] = mkv(0, 3'b011, SA, DA, 3'b001, 1, 1, D0);
      vecs[13] = mkv(0, 3'b110, SA, DA, 3'b010, 1, 2, D1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_w_en", 32'(w_en), 32'd0);
      chk("rst_w_sel", 32'(w_sel), 32'd0);
      chk("rst_w_data", w_data, 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
`ifdef WB_ARBITER_SCOREBOARD_EN
      chk("rst_busy", busy_mask, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vecs[i].hold, vecs[i].valid, vecs[i].sel, vecs[i].data);
         #1;
         chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_w_en", i), 32'(w_en), 32'(vecs[i].w_en));
         chk($sformatf("vec%0d_w_sel", i), 32'(w_sel), 32'(vecs[i].w_sel));
         chk($sformatf("vec%0d_w_data", i), w_data, vecs[i].w_data);
      end

      // All requesters valid from reset: strict rotation, one write per cycle.
      pulse_reset();
      for (int k = 0; k < 7; k++) begin
         if (k == 0) drive(1'b0, 3'b111, SA, DA);
         #1;
         chk($sformatf("rot%0d_ready", k), 32'(req_ready), 32'(1 << (k % 3)));
         @(posedge clk);
         #1;
         chk($sformatf("rot%0d_w_en", k), 32'(w_en), 32'd1);
         chk($sformatf("rot%0d_w_sel", k), 32'(w_sel), 32'((k % 3) + 1));
         @(negedge clk);
      end

      // Hold for 4 cycles; the write captured on the last grant still issues.
      hold = 1'b1;
      #1;
      chk("hold_w_en_pending", 32'(w_en), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("hold%0d_ready", k), 32'(req_ready), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("hold%0d_w_en", k), 32'(w_en), 32'd0);
         @(negedge clk);
         #1;
      end
      hold = 1'b0;
      #1;
      chk("resume_ready", 32'(req_ready), 32'b010);
      @(posedge clk);
      #1;
      chk("resume_w_sel", 32'(w_sel), 32'd2);

      // Reset during the output cycle of a grant discards the write.
      @(negedge clk);
      drive(1'b0, 3'b001, {10'd0, 5'd9}, {64'h0, 32'h0000_0099});
      #1;
      chk("mid_ready", 32'(req_ready), 32'b001);
      @(posedge clk);
      #1;
      chk("mid_w_en_pre", 32'(w_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_w_en", 32'(w_en), 32'd0);
      chk("mid_rst_w_sel", 32'(w_sel), 32'd0);
      chk("mid_rst_w_data", w_data, 32'd0);
      @(negedge clk);
      drive(1'b0, 3'b000, '0, '0);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_rst%0d_w_en", k), 32'(w_en), 32'd0);
         chk($sformatf("post_rst%0d_w_data", k), w_data, 32'd0);
      end
      @(negedge clk);
      drive(1'b0, 3'b111, SA, DA);
      #1;
      chk("post_rst_first_grant", 32'(req_ready), 32'b001);

`ifdef WB_ARBITER_SCOREBOARD_EN
      pulse_reset();
      rsv_en = 1'b1; rsv_sel = 5'd7;
      @(posedge clk); #1;
      chk("sb_set", busy_mask, 32'h80);
      @(negedge clk);
      rsv_en = 1'b0;
      @(posedge clk); #1;
      chk("sb_hold", busy_mask, 32'h80);
      @(negedge clk);
      drive(1'b0, 3'b001, {10'd0, 5'd7}, {64'h0, 32'h77});
      @(posedge clk); #1;
      chk("sb_w_en", 32'(w_en), 32'd1);
      chk("sb_before_clear", busy_mask, 32'h80);
      @(negedge clk);
      drive(1'b0, 3'b000, '0, '0);
      @(posedge clk); #1;
      chk("sb_cleared", busy_mask, 32'h0);
      @(negedge clk);
      rsv_en = 1'b1; rsv_sel = 5'd7;
      drive(1'b0, 3'b001, {10'd0, 5'd7}, {64'h0, 32'h77});
      @(posedge clk); #1;
      chk("sb_reset_bit", busy_mask, 32'h80);
      @(negedge clk);
      drive(1'b0, 3'b000, '0, '0);
      @(posedge clk); #1;
      chk("sb_set_wins", busy_mask, 32'h80);
      @(negedge clk);
      rsv_sel = 5'd0;
      @(posedge clk); #1;
      chk("sb_bit0_zero", busy_mask, 32'h80);
      @(negedge clk);
      rsv_en = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of write requesters (index 0 = ALU, 1 = LSU, 2 = debug); legal range 2..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 hold  input  1  when 1, no new grants are issued.
REQ-005 req_valid  input  N_REQ  per-requester write request.
REQ-006 req_sel  input  5*N_REQ  per-requester destination register; slice i = bits [5i+4:5i].
REQ-007 req_data  input  32*N_REQ  per-requester write data; slice i = bits [32i+31:32i].
REQ-008 req_ready  output  N_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 w_en  output  1  register-file write enable.
REQ-010 w_sel  output  5  register-file write index.
REQ-011 w_data  output  32  register-file write data.
REQ-012 rsv_en  input  1  reserve a destination (scoreboard build only).
REQ-013 rsv_sel  input  5  register to reserve (scoreboard build only).
REQ-014 busy_mask  output  32  per-register pending-write flags (scoreboard build only).

Function
REQ-015 req_ready shall be combinational; it is at most one-hot, and is all-zero when hold=1 or no req_valid bit is set.
REQ-016 Arbitration shall be round-robin: search starts at index rr_ptr and wraps modulo N_REQ.
REQ-017 After a transfer from index g, rr_ptr shall become (g+1) mod N_REQ; with no transfer, rr_ptr shall hold.
REQ-018 The transferred sel/data shall be registered into the output stage; w_en/w_sel/w_data shall appear exactly 1 cycle after the transfer.
REQ-019 w_en shall be 1 for exactly one cycle per transfer with sel != 0.
REQ-020 A transfer with sel = 0 shall be accepted (ready asserted) but shall produce w_en = 0; w_sel and w_data shall still update.
REQ-021 With no transfer, w_en shall be 0 the next cycle, and w_sel/w_data shall hold their last values.
REQ-022 Throughput shall be one write per cycle; the output stage never stalls, since the register file is always ready.
REQ-023 A requester that holds req_valid shall be granted within N_REQ cycles while hold=0.
REQ-024 hold shall affect only new grants; an output-stage write already captured shall still issue.

Reset
REQ-025 While rst_n = 0: w_en = 0, w_sel = 0, w_data = 0, rr_ptr = 0, and busy_mask = 0.
REQ-026 A reset asserted mid-operation shall discard any captured, not-yet-issued write, with no w_en pulse after reset.
REQ-027 The first grant after reset release shall favour index 0.

Configuration
REQ-028 Macro WB_ARBITER_SCOREBOARD_EN shall compile in the scoreboard ports and logic (REQ-012..014, REQ-029..032).
REQ-029 With the macro: rsv_en=1 with rsv_sel != 0 shall set busy_mask[rsv_sel] on the next edge.
REQ-030 With the macro: each w_en pulse shall clear busy_mask[w_sel] on the same edge.
REQ-031 With the macro: a simultaneous set and clear of the same register shall leave the bit set (set wins); busy_mask[0] shall always be 0.
REQ-032 Without the macro: the rsv_en, rsv_sel and busy_mask ports shall be absent, and arbitration behaviour shall be identical.

Structure
REQ-033 A shared package shall hold REG_IDX_W = 5, XLEN = 32, the requester-index constants (REQ_ALU, REQ_LSU, REQ_DBG) and the default N_REQ.
REQ-034 The round-robin grant logic shall be one sub-module, rr_arbiter (inputs req/ptr, output one-hot grant), instantiated once.

Verification
REQ-035 Reset, then ALU valid with sel=5, data=0xDEADBEEF -> ready[0] in the same cycle; next cycle w_en=1, w_sel=5, w_data=0xDEADBEEF.
REQ-036 All three requesters valid continuously from reset -> grant order 0,1,2,0,1,2, and w_en high every cycle.
REQ-037 LSU request with sel=0, data=0x1234 -> ready[1]=1; next cycle w_en=0.
REQ-038 hold=1 with all requesters valid for 4 cycles -> req_ready=0 throughout; release -> grant resumes at the held rr_ptr.
REQ-039 Scoreboard build: rsv x7, then ALU write to x7 two cycles later -> busy_mask[7]=1 until the w_en edge, then 0; rsv x7 on that same edge -> stays 1.
REQ-040 rst_n pulsed low in the cycle after a grant -> no w_en pulse follows, and all outputs read 0.
